// File: rtl/ffd_arbiter_pkg.sv
// Shared types and defaults for the round-robin
// arbiter that owns a single flip-flop register.
package ffd_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int DEF_NB_REQ  = 4;
  localparam int DEF_WIDTH   = 8;
  localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/ffd_arbiter_rr_select.sv
// Combinational round-robin picker: first set
// request at or above ptr, wrapping to index 0.
module rr_select
  import ffd_arbiter_pkg::*;
#(
  parameter int N  = DEF_NB_REQ,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [IW-1:0] j;

  // Scan from the far end so the nearest hit wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = IW'((int'(ptr) + i) % N);
      if (req[j]) begin
        idx   = j;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ffd_arbiter.sv
// Round-robin burst arbiter: one requester at a
// time owns and writes the shared register q.
module ffd_arbiter
  import ffd_arbiter_pkg::*;
#(
  parameter int NB_REQ  = DEF_NB_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT,
  localparam int OW = (NB_REQ > 1) ? $clog2(NB_REQ) : 1,
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic                    aclk,
  input  logic                    srst,
  input  logic [NB_REQ-1:0]       req_valid,
  input  logic [NB_REQ-1:0]       req_last,
  input  logic [NB_REQ*WIDTH-1:0] req_data,
  output logic [NB_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]        q,
  output logic                    q_valid,
  output logic [OW-1:0]           owner,
  output logic                    busy
);

  state_e            state_q, state_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [OW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     idle_q, idle_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic              qv_q, qv_d;
  logic [NB_REQ-1:0] rdy_q, rdy_d;

  logic [OW-1:0]     pick;
  logic              found;
  logic              own_valid;
  logic              own_last;
  logic [WIDTH-1:0]  own_data;
  logic              xfer;
  logic              expire;
  logic [OW-1:0]     ptr_nxt;

  rr_select #(
    .N  (NB_REQ),
    .IW (OW)
  ) u_sel (
    .req   (req_valid),
    .ptr   (ptr_q),
    .idx   (pick),
    .found (found)
  );

  assign own_valid = req_valid[owner_q];
  assign own_last  = req_last[owner_q];
  assign own_data  = req_data[owner_q*WIDTH +: WIDTH];
  assign xfer      = (state_q == LOCKED) && own_valid
                   && rdy_q[owner_q];
  assign expire    = (TIMEOUT > 0) && !own_valid
                   && (idle_q == CW'(TIMEOUT - 1));
  assign ptr_nxt   = (owner_q == OW'(NB_REQ - 1))
                   ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    idle_d  = idle_q;
    q_d     = q_q;
    qv_d    = 1'b0;
    rdy_d   = rdy_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = LOCKED;
          owner_d = pick;
          idle_d  = '0;
          rdy_d   = NB_REQ'(1) << pick;
        end
      end
      LOCKED: begin
        if (xfer) begin
          q_d    = own_data;
          qv_d   = 1'b1;
          idle_d = '0;
          if (own_last) begin
            state_d = IDLE;
            ptr_d   = ptr_nxt;
            rdy_d   = '0;
          end
        end else if (expire) begin
          state_d = IDLE;
          ptr_d   = ptr_nxt;
          idle_d  = '0;
          rdy_d   = '0;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        rdy_d   = '0;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      idle_q  <= '0;
      q_q     <= '0;
      qv_q    <= 1'b0;
      rdy_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      idle_q  <= idle_d;
      q_q     <= q_d;
      qv_q    <= qv_d;
      rdy_q   <= rdy_d;
    end
  end

  assign req_ready = rdy_q;
  assign q         = q_q;
  assign q_valid   = qv_q;
  assign owner     = owner_q;
  assign busy      = (state_q == LOCKED);

endmodule

// File: tb/tb_ffd_arbiter.sv
// Directed and randomized checks of ffd_arbiter
// against a behavioural grant/transfer model.
module tb_ffd_arbiter;

  localparam int NB = 4;
  localparam int W  = 8;
  localparam int TO = 16;

  logic          aclk = 1'b0;
  logic          srst;
  logic [NB-1:0] req_valid;
  logic [NB-1:0] req_last;
  logic [NB*W-1:0] req_data;
  logic [NB-1:0] req_ready;
  logic [W-1:0]  q;
  logic          q_valid;
  logic [1:0]    owner;
  logic          busy;

  int checks = 0;
  int errors = 0;

  bit         m_busy;
  int         m_owner;
  int         m_ptr;
  int         m_idle;
  logic [W-1:0] m_q;
  bit         m_qv;

  always #5 aclk = ~aclk;

  ffd_arbiter #(
    .NB_REQ  (NB),
    .WIDTH   (W),
    .TIMEOUT (TO)
  ) dut (
    .aclk      (aclk),
    .srst      (srst),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .q         (q),
    .q_valid   (q_valid),
    .owner     (owner),
    .busy      (busy)
  );

  function automatic logic [NB-1:0] m_ready();
    return m_busy ? (NB'(1) << m_owner) : '0;
  endfunction

  task automatic set_data(input int i, input logic [W-1:0] v);
    req_data[i*W +: W] = v;
  endtask

  // Advance one edge; the model sees the inputs held at that edge.
  task automatic cycle();
    logic [NB-1:0]   v, l;
    logic [NB*W-1:0] d;
    logic            r;
    bit              hit;
    v = req_valid; l = req_last; d = req_data; r = srst;
    @(posedge aclk);
    m_qv = 0;
    if (r) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_idle = 0; m_q = '0;
    end else if (!m_busy) begin
      hit = 0;
      for (int k = 0; k < NB; k++) begin
        if (!hit && v[(m_ptr + k) % NB]) begin
          hit = 1; m_busy = 1; m_owner = (m_ptr + k) % NB; m_idle = 0;
        end
      end
    end else if (v[m_owner]) begin
      m_q = d[m_owner*W +: W]; m_qv = 1; m_idle = 0;
      if (l[m_owner]) begin
        m_busy = 0; m_ptr = (m_owner + 1) % NB;
      end
    end else begin
      m_idle++;
      if (TO > 0 && m_idle >= TO) begin
        m_busy = 0; m_ptr = (m_owner + 1) % NB; m_idle = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    srst = 1; req_valid = '0; req_last = '0;
    cycle();
    srst = 0;
  endtask

  task automatic test_reset();
    srst = 1; req_valid = '0; req_last = '0; req_data = '0;
    repeat (5) cycle();
    srst = 0;
    cycle();
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q: got %h exp 00", q); end
    checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL reset_qv: got %b exp 0", q_valid); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b exp 0000", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (owner !== 2'd0) begin errors++; $display("FAIL reset_owner: got %0d exp 0", owner); end
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0100; req_last = 4'b0100; set_data(2, 8'hA5);
    cycle();
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b exp 0100", req_ready); end
    checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL single_qv_early: got %b exp 0", q_valid); end
    checks++; if (owner !== 2'd2) begin errors++; $display("FAIL single_owner: got %0d exp 2", owner); end
    cycle();
    req_valid = '0;
    checks++; if (q !== 8'hA5) begin errors++; $display("FAIL single_q: got %h exp a5", q); end
    checks++; if (q_valid !== 1'b1) begin errors++; $display("FAIL single_qv: got %b exp 1", q_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got %b exp 0", busy); end
    req_valid = 4'b1101; req_last = 4'b1111;
    cycle();
    req_valid = '0;
    checks++; if (owner !== 2'd3) begin errors++; $display("FAIL single_ptr: got %0d exp 3", owner); end
  endtask

  task automatic test_fairness();
    int n;
    logic [W-1:0] eq;
    do_reset();
    req_valid = '1; req_last = '1;
    for (int i = 0; i < NB; i++) set_data(i, W'(8'h10 + i));
    n = 0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      cycle();
      if (q_valid) begin
        eq = W'(8'h10 + (n % NB));
        checks++; if (q !== eq) begin errors++; $display("FAIL fair_q[%0d]: got %h exp %h", n, q, eq); end
        checks++; if (owner !== 2'(n % NB)) begin errors++; $display("FAIL fair_owner[%0d]: got %0d exp %0d", n, owner, n % NB); end
        n++;
      end
    end
    checks++; if (n != 5) begin errors++; $display("FAIL fair_count: got %0d exp 5", n); end
    req_valid = '0;
  endtask

  task automatic test_burst();
    logic [W-1:0] exq [5] = '{8'hEE, 8'h11, 8'h22, 8'h33, 8'hEE};
    logic [1:0]   exo [5] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
    logic [W-1:0] beats [3] = '{8'h11, 8'h22, 8'h33};
    int n, b;
    do_reset();
    req_valid = 4'b0001; req_last = 4'b0001; set_data(0, 8'hEE);
    cycle();
    req_valid = 4'b0011; set_data(1, beats[0]);
    n = 0; b = 0;
    for (int c = 0; c < 60 && n < 5; c++) begin
      cycle();
      if (q_valid) begin
        checks++; if (q !== exq[n]) begin errors++; $display("FAIL burst_q[%0d]: got %h exp %h", n, q, exq[n]); end
        checks++; if (owner !== exo[n]) begin errors++; $display("FAIL burst_owner[%0d]: got %0d exp %0d", n, owner, exo[n]); end
        if (n >= 1 && n <= 3) b++;
        n++;
        if (b < 3) begin
          set_data(1, beats[b]); req_last[1] = (b == 2);
        end else begin
          req_valid[1] = 1'b0;
        end
      end
    end
    checks++; if (n != 5) begin errors++; $display("FAIL burst_count: got %0d exp 5", n); end
    req_valid = '0;
  endtask

  task automatic test_timeout();
    do_reset();
    req_valid = 4'b1000; req_last = 4'b0000; set_data(3, 8'h5A);
    cycle();
    cycle();
    req_valid = '0;
    repeat (TO - 1) cycle();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL to_early: got %b exp 1", busy); end
    cycle();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_busy: got %b exp 0", busy); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL to_ready: got %b exp 0000", req_ready); end
    checks++; if (q !== 8'h5A) begin errors++; $display("FAIL to_q: got %h exp 5a", q); end
    checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL to_qv: got %b exp 0", q_valid); end
    req_valid = 4'b1001;
    cycle();
    req_valid = '0;
    checks++; if (owner !== 2'd0) begin errors++; $display("FAIL to_ptr: got %0d exp 0", owner); end
  endtask

  task automatic test_midreset();
    int n;
    do_reset();
    req_valid = 4'b0100; req_last = 4'b0000; set_data(2, 8'h01);
    n = 0;
    for (int c = 0; c < 20 && n < 2; c++) begin
      cycle();
      if (q_valid) begin
        n++; set_data(2, W'(n + 1));
      end
    end
    checks++; if (n != 2) begin errors++; $display("FAIL mid_prefix: got %0d exp 2", n); end
    srst = 1;
    cycle();
    srst = 0; req_valid = '0;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL mid_q: got %h exp 00", q); end
    checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL mid_qv: got %b exp 0", q_valid); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_ready: got %b exp 0000", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b exp 0", busy); end
    checks++; if (owner !== 2'd0) begin errors++; $display("FAIL mid_owner: got %0d exp 0", owner); end
    repeat (3) cycle();
    checks++; if (busy !== 1'b0 || q !== 8'h00) begin errors++; $display("FAIL mid_resume: got busy=%b q=%h exp busy=0 q=00", busy, q); end
  endtask

  task automatic test_random();
    int thr;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      thr = (c / 250) % 3 == 0 ? 7 : ((c / 250) % 3 == 1 ? 3 : 0);
      for (int i = 0; i < NB; i++) begin
        req_valid[i] = ($urandom_range(0, 9) < thr);
        req_last[i]  = ($urandom_range(0, 2) == 0);
        set_data(i, W'($urandom));
      end
      srst = ($urandom_range(0, 99) == 0);
      cycle();
      checks++; if (q !== m_q) begin errors++; $display("FAIL rnd_q@%0d: got %h exp %h", c, q, m_q); end
      checks++; if (q_valid !== m_qv) begin errors++; $display("FAIL rnd_qv@%0d: got %b exp %b", c, q_valid, m_qv); end
      checks++; if (req_ready !== m_ready()) begin errors++; $display("FAIL rnd_ready@%0d: got %b exp %b", c, req_ready, m_ready()); end
      checks++; if (busy !== m_busy) begin errors++; $display("FAIL rnd_busy@%0d: got %b exp %b", c, busy, m_busy); end
      checks++; if (owner !== 2'(m_owner)) begin errors++; $display("FAIL rnd_owner@%0d: got %0d exp %0d", c, owner, m_owner); end
    end
    srst = 0; req_valid = '0;
  endtask

  initial begin
    m_busy = 0; m_owner = 0; m_ptr = 0; m_idle = 0; m_q = '0; m_qv = 0;
    test_reset();
    test_single();
    test_fairness();
    test_burst();
    test_timeout();
    test_midreset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ffd_arbiter.md
FFD_ARBITER -- requirements
Module: ffd_arbiter

Interface
REQ-001 The block SHALL have parameter NB_REQ, default 4, meaning the number of requesters (1..16).
REQ-002 The block SHALL have parameter WIDTH, default 8, meaning the width of the shared flip-flop register.
REQ-003 The block SHALL have parameter TIMEOUT, default 16, meaning idle-owner cycles before forced release (0 disables the timeout).
REQ-004 aclk  input  1  the single clock; all logic is sampled on its rising edge.
REQ-005 srst  input  1  reset, synchronous and active-high.
REQ-006 req_valid  input  NB_REQ  per-requester beat valid.
REQ-007 req_last  input  NB_REQ  per-requester last beat of burst.
REQ-008 req_data  input  NB_REQ*WIDTH  per-requester data; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-009 req_ready  output  NB_REQ  per-requester ready; at most one bit is high.
REQ-010 q  output  WIDTH  shared register content.
REQ-011 q_valid  output  1  single-cycle pulse, high for one cycle after each q update.
REQ-012 owner  output  clog2(NB_REQ), min 1  index of the current grant holder; holds its last value when idle.
REQ-013 busy  output  1  high while in state LOCKED.

Function
REQ-014 The FSM SHALL have two states: IDLE (no grant) and LOCKED (one requester owns q).
REQ-015 In IDLE, with any req_valid high, the block SHALL pick the first valid index at or above rr_ptr, wrapping from NB_REQ-1 to 0, load owner and enter LOCKED on the next edge.
REQ-016 In IDLE, req_ready SHALL be all-zero; in LOCKED, req_ready[owner] SHALL be 1 and all other bits 0.
REQ-017 A transfer SHALL occur when req_valid[owner] and req_ready[owner] are both high; q then takes req_data[owner] on that edge and q_valid is 1 for the following cycle.
REQ-018 Latency: valid held from cycle t in IDLE -> ready at t+1 -> q and q_valid at t+2.
REQ-019 A transfer with req_last[owner]=1 SHALL return the FSM to IDLE and set rr_ptr to (owner+1) mod NB_REQ, wrapping NB_REQ-1 to 0.
REQ-020 A beat with last on the first transfer SHALL be a legal single-beat grant; every grant costs one IDLE bubble cycle.
REQ-021 In LOCKED, valid/last/data of non-owners SHALL be ignored, and q SHALL hold when no transfer occurs.
REQ-022 In LOCKED, an idle counter SHALL increment each cycle req_valid[owner]=0 and clear on any transfer.
REQ-023 With TIMEOUT>0, the idle counter reaching TIMEOUT SHALL force IDLE and advance rr_ptr as in REQ-019, with no q update.
REQ-024 When every requester is continuously valid with last=1, grants SHALL rotate 0,1,...,NB_REQ-1,0.
REQ-025 With NB_REQ=1, the block SHALL behave as a single-owner register with one bubble per burst.

Reset
REQ-026 With srst high at a rising edge, the block SHALL set state=IDLE, rr_ptr=0, owner=0, idle counter=0, q=0, q_valid=0, req_ready=0 and busy=0 on that edge, including mid-burst, with no q update from a beat presented in the reset cycle.

Structure
REQ-027 Package ffd_arbiter_pkg SHALL hold the state enum (IDLE, LOCKED) and the default parameter constants.
REQ-028 Sub-module rr_select SHALL be a combinational round-robin picker (inputs: request vector, pointer; outputs: index, found), instantiated once.

Verification
REQ-029 Reset check: srst=1 for 5 cycles then 0 -> q=0, q_valid=0, req_ready=0, busy=0.
REQ-030 Single beat: req_valid[2]=1, last[2]=1, data=8'hA5 from IDLE -> ready[2] at t+1, q=8'hA5 with q_valid at t+2, IDLE at t+2, rr_ptr=3.
REQ-031 Fairness: all 4 requesters valid with last=1 and data=8'h10+i -> q sequence 10,11,12,13,10; owner 0,1,2,3,0.
REQ-032 Burst lock: req 1 sends 3 beats (11,22,33; last on 33) while req 0 is valid -> q=11,22,33 with no req 0 beat between them; req 0 granted next.
REQ-033 Timeout: owner 3 drops valid for 16 cycles -> IDLE, busy=0, q unchanged, rr_ptr=0.
REQ-034 Mid-burst reset: srst pulsed after beat 2 of 4 -> all outputs at reset values the next cycle and the burst does not resume.
